// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine plant timer: state encoding,
// widths and default parameter values.
package wm_pkg;

  localparam int PHASE_W        = 3;
  localparam int CNT_W          = 8;
  localparam int LEVEL_W        = 4;
  localparam int FILL_LEVEL_DEF = 8;
  localparam int WASH_TICKS_DEF = 16;
  localparam int SPIN_TICKS_DEF = 12;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WASH    = 3'd1,
    ST_WASH_TO = 3'd2,
    ST_SPIN    = 3'd3,
    ST_SPIN_TO = 3'd4
  } state_t;

endpackage

// File: rtl/wm_phase_counter.sv
// Shared phase up-counter with synchronous clear, enable and a
// terminal-count compare against a selectable terminal value.
module wm_phase_counter
  import wm_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/wm_plant_timer.sv
// Washing-machine plant model: water level integrator plus wash/spin phase
// timer with held timeout flags. All outputs decode from registers.
//   state      | meaning
//   IDLE       | no phase running, counter held at 0
//   WASH       | counting wash ticks
//   WASH_TO    | wash expired, cycle_timeout held
//   SPIN       | counting spin ticks
//   SPIN_TO    | spin expired, spin_timeout held until motor off or done
module wm_plant_timer
  import wm_pkg::*;
#(
  parameter int FILL_LEVEL = FILL_LEVEL_DEF,
  parameter int WASH_TICKS = WASH_TICKS_DEF,
  parameter int SPIN_TICKS = SPIN_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               motor_on,
  input  logic               soap_wash,
  input  logic               water_wash,
  input  logic               done,
  output logic               filled,
  output logic               drained,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [LEVEL_W-1:0] FILL_L  = LEVEL_W'(FILL_LEVEL);
  localparam logic [CNT_W-1:0]   WASH_TC = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0]   SPIN_TC = CNT_W'(SPIN_TICKS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEVEL_W-1:0] r_level;
  logic [1:0]         r_type;
  logic [1:0]         w_type;
  logic               w_type_chg;
  logic               w_filled;
  logic               w_drained;
  logic               w_tc;
  logic               w_clr;
  logic               w_en;
  logic [CNT_W-1:0]   w_terminal;

  assign w_type     = {soap_wash, water_wash};
  assign w_type_chg = (w_type != r_type);
  assign w_filled   = (r_level == FILL_L);
  assign w_drained  = (r_level == '0);
  assign w_terminal = (r_state == ST_SPIN) ? SPIN_TC : WASH_TC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      r_type  <= '0;
    end else begin
      r_type <= w_type;
      if (fill_value_on && !drain_value_on && !w_filled)
        r_level <= r_level + 1'b1;
      else if (drain_value_on && !fill_value_on && !w_drained)
        r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counter is cleared everywhere except while a phase is actively counting;
  // motor_on=0 is checked before terminal count so an abort never times out.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b1;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (motor_on && w_filled && !drain_value_on)
          w_state_nxt = ST_WASH;
        else if (motor_on && drain_value_on && w_drained)
          w_state_nxt = ST_SPIN;
      end
      ST_WASH: begin
        if (!motor_on || drain_value_on) w_state_nxt = ST_IDLE;
        else if (w_type_chg)             w_state_nxt = ST_WASH;
        else if (w_tc)                   w_state_nxt = ST_WASH_TO;
        else begin
          w_clr = 1'b0;
          w_en  = 1'b1;
        end
      end
      ST_WASH_TO: begin
        if (!motor_on || drain_value_on) w_state_nxt = ST_IDLE;
        else if (w_type_chg)             w_state_nxt = ST_WASH;
      end
      ST_SPIN: begin
        if (!motor_on)  w_state_nxt = ST_IDLE;
        else if (w_tc)  w_state_nxt = ST_SPIN_TO;
        else begin
          w_clr = 1'b0;
          w_en  = 1'b1;
        end
      end
      ST_SPIN_TO: begin
        if (!motor_on || done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  wm_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clear    (w_clr),
    .i_enable   (w_en),
    .i_terminal (w_terminal),
    .o_tc       (w_tc)
  );

  assign filled        = w_filled;
  assign drained       = w_drained;
  assign cycle_timeout = (r_state == ST_WASH_TO);
  assign spin_timeout  = (r_state == ST_SPIN_TO);
  assign water_level   = r_level;
  assign phase         = r_state;

endmodule

// File: tb/tb_wm_plant_timer.sv
// Self-checking bench for wm_plant_timer: a behavioural plant model pushes the
// expected post-edge outputs into a scoreboard, popped after each edge.
module tb_wm_plant_timer;

  localparam int FILL = 8;
  localparam int WASH = 16;
  localparam int SPIN = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fill_value_on = 1'b0;
  logic       drain_value_on = 1'b0;
  logic       motor_on = 1'b0;
  logic       soap_wash = 1'b0;
  logic       water_wash = 1'b0;
  logic       done = 1'b0;
  logic       filled;
  logic       drained;
  logic       cycle_timeout;
  logic       spin_timeout;
  logic [3:0] water_level;
  logic [2:0] phase;

  wm_plant_timer #(
    .FILL_LEVEL (FILL),
    .WASH_TICKS (WASH),
    .SPIN_TICKS (SPIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fill_value_on  (fill_value_on),
    .drain_value_on (drain_value_on),
    .motor_on       (motor_on),
    .soap_wash      (soap_wash),
    .water_wash     (water_wash),
    .done           (done),
    .filled         (filled),
    .drained        (drained),
    .cycle_timeout  (cycle_timeout),
    .spin_timeout   (spin_timeout),
    .water_level    (water_level),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    level;
    int    filled;
    int    drained;
    int    cto;
    int    sto;
    int    phase;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Plant model: mode 0 idle, 1 wash, 2 spin; m_t counts edges since phase
  // (re)start and saturates at the phase length, which means "timed out".
  int         m_level;
  int         m_mode;
  int         m_t;
  logic [1:0] m_type;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_mode  = 0;
    m_t     = 0;
    m_type  = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] ty;
    ty = {soap_wash, water_wash};
    case (m_mode)
      0: begin
        if (motor_on && m_level == FILL && !drain_value_on) begin
          m_mode = 1; m_t = 0;
        end else if (motor_on && drain_value_on && m_level == 0) begin
          m_mode = 2; m_t = 0;
        end
      end
      1: begin
        if (!motor_on || drain_value_on) begin
          m_mode = 0; m_t = 0;
        end else if (ty != m_type) m_t = 0;
        else if (m_t < WASH) m_t++;
      end
      default: begin
        if (!motor_on) begin
          m_mode = 0; m_t = 0;
        end else if (m_t == SPIN) begin
          if (done) begin
            m_mode = 0; m_t = 0;
          end
        end else m_t++;
      end
    endcase
    if (fill_value_on && !drain_value_on && m_level < FILL) m_level++;
    else if (drain_value_on && !fill_value_on && m_level > 0) m_level--;
    m_type = ty;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag     = tag;
    e.level   = m_level;
    e.filled  = (m_level == FILL) ? 1 : 0;
    e.drained = (m_level == 0) ? 1 : 0;
    e.cto     = (m_mode == 1 && m_t == WASH) ? 1 : 0;
    e.sto     = (m_mode == 2 && m_t == SPIN) ? 1 : 0;
    case (m_mode)
      0:       e.phase = 0;
      1:       e.phase = (m_t == WASH) ? 2 : 1;
      default: e.phase = (m_t == SPIN) ? 4 : 3;
    endcase
    sb.push_back(e);
  endtask

  task automatic drive(input logic f, input logic d, input logic m,
                       input logic s, input logic w, input logic dn);
    fill_value_on  = f;
    drain_value_on = d;
    motor_on       = m;
    soap_wash      = s;
    water_wash     = w;
    done           = dn;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    push_exp(tag);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".level"},   water_level,   e.level);
      chk({e.tag, ".filled"},  filled,        e.filled);
      chk({e.tag, ".drained"}, drained,       e.drained);
      chk({e.tag, ".cto"},     cycle_timeout, e.cto);
      chk({e.tag, ".sto"},     spin_timeout,  e.sto);
      chk({e.tag, ".phase"},   phase,         e.phase);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".level"},   water_level,   0);
    chk({tag, ".filled"},  filled,        0);
    chk({tag, ".drained"}, drained,       1);
    chk({tag, ".cto"},     cycle_timeout, 0);
    chk({tag, ".sto"},     spin_timeout,  0);
    chk({tag, ".phase"},   phase,         0);
  endtask

  always @(negedge clk) chk("excl_timeouts", cycle_timeout & spin_timeout, 0);

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #3;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // fill ramp and saturation
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick("fill");
      chk("fill_ramp", water_level, (i < FILL) ? i : FILL);
      chk("fill_flag", filled, (i >= FILL) ? 1 : 0);
    end

    // soap wash times out after WASH edges, held, then restarts on type change
    drive(0, 0, 1, 1, 0, 0);
    tick("wash_entry");
    for (int i = 1; i <= WASH; i++) begin
      tick("wash_soap");
      chk("cto_rise", cycle_timeout, (i == WASH) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick("wash_hold");
      chk("cto_held", cycle_timeout, 1);
    end
    drive(0, 0, 1, 0, 1, 0);
    tick("wash_flip");
    chk("cto_clear", cycle_timeout, 0);
    for (int i = 1; i <= WASH; i++) begin
      tick("wash_water");
      chk("cto_rerise", cycle_timeout, (i == WASH) ? 1 : 0);
    end

    // motor drop exactly at terminal count resolves to idle, no timeout
    drive(0, 0, 0, 0, 1, 0);
    tick("motor_off");
    drive(0, 0, 1, 0, 1, 0);
    tick("rewash_entry");
    for (int i = 1; i < WASH; i++) tick("rewash");
    drive(0, 0, 0, 0, 1, 0);
    tick("abort_tc");
    chk("abort_cto", cycle_timeout, 0);
    chk("abort_phase", phase, 0);

    // type change mid-wash restarts the count
    drive(0, 0, 1, 0, 1, 0);
    tick("midwash_entry");
    for (int i = 0; i < 8; i++) tick("midwash");
    drive(0, 0, 1, 1, 1, 0);
    tick("midwash_flip");
    for (int i = 1; i <= WASH; i++) begin
      tick("midwash_restart");
      chk("cto_after_flip", cycle_timeout, (i == WASH) ? 1 : 0);
    end

    // drain during wash timeout returns to idle, level keeps tracking
    drive(0, 1, 1, 1, 1, 0);
    tick("wash_drain");
    chk("wash_drain_phase", phase, 0);
    chk("wash_drain_level", water_level, FILL - 1);
    drive(1, 0, 0, 0, 0, 0);
    tick("refill");

    // drain to empty, then spin timeout and done
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= FILL; i++) begin
      tick("drain");
      chk("drained_flag", drained, (i == FILL) ? 1 : 0);
    end
    drive(0, 1, 1, 0, 0, 0);
    tick("spin_entry");
    chk("spin_phase", phase, 3);
    for (int i = 1; i <= SPIN; i++) begin
      tick("spin");
      chk("sto_rise", spin_timeout, (i == SPIN) ? 1 : 0);
    end
    drive(0, 1, 1, 0, 0, 1);
    tick("spin_done");
    chk("sto_clear", spin_timeout, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick("post_done");

    // async reset mid-spin aborts without a clock edge
    drive(0, 1, 1, 0, 0, 0);
    tick("spin2_entry");
    for (int i = 0; i < 5; i++) tick("spin2");
    #1 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < SPIN + 3; i++) begin
      tick("post_reset");
      chk("no_sto_after_reset", spin_timeout, 0);
    end

    // both valves on holds the level
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("fill4");
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick("both_valves");
      chk("hold_level", water_level, 4);
    end
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("drain4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
